// File: rtl/jpeg_dec_tb_pkg.sv
// Shared definitions for the JPEG decoder block-stream generator.
// Holds the chroma-sampling and length-range encodings, the MCU length and
// component ID tables, the LFSR feedback mask and the blank/burst draw rules.
package jpeg_dec_tb_pkg;

  typedef enum logic [1:0] {
    Mode444  = 2'd0,
    Mode422  = 2'd1,
    Mode420  = 2'd2,
    ModeGray = 2'd3
  } chroma_mode_e;

  typedef enum logic [1:0] {
    RangeShort    = 2'd0,
    RangeLong     = 2'd1,
    RangeVeryLong = 2'd2,
    RangeFixed    = 2'd3
  } len_mode_e;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  localparam logic [15:0] BlankLongBase  = 16'd128;
  localparam logic [15:0] BlankVLongBase = 16'd1024;
  localparam logic [8:0]  BurstShortBase = 9'd1;
  localparam logic [8:0]  BurstLongBase  = 9'd33;
  localparam logic [8:0]  BurstVLongBase = 9'd129;

  // Codes 4-7 fall back to grayscale.
  function automatic chroma_mode_e decode_mode(input logic [2:0] m);
    chroma_mode_e r;
    r = m[2] ? ModeGray : chroma_mode_e'(m[1:0]);
    return r;
  endfunction

  function automatic logic [2:0] mcu_len(input chroma_mode_e m);
    logic [2:0] r;
    case (m)
      Mode444: r = 3'd3;
      Mode422: r = 3'd4;
      Mode420: r = 3'd6;
      default: r = 3'd1;
    endcase
    return r;
  endfunction

  // Luma blocks first, then Cb, then Cr within one MCU.
  function automatic logic [1:0] comp_id(input chroma_mode_e m, input logic [2:0] idx);
    logic [1:0] r;
    case (m)
      Mode444: r = idx[1:0];
      Mode422: r = (idx < 3'd2) ? 2'd0 : idx[1:0] - 2'd1;
      Mode420: r = (idx < 3'd4) ? 2'd0 : idx[1:0] + 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] fix_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [15:0] blank_draw(input len_mode_e m, input logic [31:0] l,
                                             input logic [15:0] fixed_len);
    logic [15:0] r;
    case (m)
      RangeShort:    r = {13'd0, l[2:0]};
      RangeLong:     r = BlankLongBase + {9'd0, l[6:0]};
      RangeVeryLong: r = BlankVLongBase + {6'd0, l[9:0]};
      default:       r = fixed_len;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] burst_draw(input len_mode_e m, input logic [31:0] l,
                                            input logic [7:0] fixed_len);
    logic [8:0] r;
    case (m)
      RangeShort:    r = BurstShortBase + {7'd0, l[1:0]};
      RangeLong:     r = BurstLongBase + {4'd0, l[4:0]};
      RangeVeryLong: r = BurstVLongBase + {2'd0, l[6:0]};
      default:       r = (fixed_len == 8'd0) ? 9'd1 : {1'b0, fixed_len};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jpeg_dec_lfsr32.sv
// 32-bit Galois LFSR.
// Ports: iCLK/iRSTN clock and async active-low reset; en steps the register;
// load copies seed in (takes priority over en); state is the current value.
module jpeg_dec_lfsr32
  import jpeg_dec_tb_pkg::*;
#(
  parameter logic [31:0] ResetVal = 32'h1
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  logic [31:0] state_q;

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q <= ResetVal;
    end else if (load) begin
      state_q <= seed;
    end else if (en) begin
      state_q <= state_q[0] ? ((state_q >> 1) ^ LfsrPoly) : (state_q >> 1);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/jpeg_dec_blk_stream_gen.sv
// Block-stream generator: replays samples from an external memory as
// 2^BLK_LOG2-sample blocks in blank/burst patterns, tagging each block with
// its component ID and honouring downstream backpressure.
// Ports: iSTART/iBLOCKS/iMODE/iBLANK_*/iBURST_* run configuration (captured
// at start); oMEM_ADDR/iMEM_DAT memory read; oPO_EN/iPO_RDY/oPO handshake and
// data; oPO_DC/oPO_LAST first/last sample flags; oPO_ID component ID;
// oBUSY run in progress; oDONE end-of-run pulse.
module jpeg_dec_blk_stream_gen
  import jpeg_dec_tb_pkg::*;
#(
  parameter int unsigned DW        = 12,
  parameter int unsigned BLK_LOG2  = 6,
  parameter int unsigned AW        = 22,
  parameter logic [31:0] LFSR_SEED = 32'hACE11234
) (
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          iSTART,
  input  logic [31:0]   iBLOCKS,
  input  logic [2:0]    iMODE,
  input  logic [1:0]    iBLANK_MOD,
  input  logic [15:0]   iBLANK_VAL,
  input  logic [1:0]    iBURST_MOD,
  input  logic [7:0]    iBURST_VAL,
  output logic [AW-1:0] oMEM_ADDR,
  input  logic [DW-1:0] iMEM_DAT,
  output logic          oPO_EN,
  input  logic          iPO_RDY,
  output logic [DW-1:0] oPO,
  output logic          oPO_DC,
  output logic          oPO_LAST,
  output logic [1:0]    oPO_ID,
  output logic          oBUSY,
  output logic          oDONE
);

  typedef enum logic [1:0] {StIdle, StBlank, StBurst, StDone} state_e;

  localparam logic [BLK_LOG2-1:0] CntMax    = '1;
  localparam logic [31:0]         SeedFixed = fix_seed(LFSR_SEED);

  state_e              state_q;
  chroma_mode_e        mode_q;
  len_mode_e           blank_mode_q, burst_mode_q;
  logic [15:0]         blank_val_q, blank_cnt_q;
  logic [7:0]          burst_val_q;
  logic [8:0]          burst_cnt_q;
  logic [31:0]         blocks_left_q;
  logic [AW-1:0]       addr_q;
  logic [BLK_LOG2-1:0] cnt_q;
  logic [2:0]          mcu_idx_q;
  logic                en_q, busy_q, done_q;
  logic [31:0]         lfsr;
  logic                xfer;
  logic [2:0]          mcu_last;

  assign xfer     = en_q & iPO_RDY;
  assign mcu_last = mcu_len(mode_q) - 3'd1;

  jpeg_dec_lfsr32 #(
    .ResetVal(SeedFixed)
  ) u_lfsr (
    .iCLK (iCLK),
    .iRSTN(iRSTN),
    .en   (state_q != StIdle),
    .load ((state_q == StIdle) && iSTART),
    .seed (SeedFixed),
    .state(lfsr)
  );

  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      state_q       <= StIdle;
      mode_q        <= Mode444;
      blank_mode_q  <= RangeShort;
      burst_mode_q  <= RangeShort;
      blank_val_q   <= '0;
      burst_val_q   <= '0;
      blank_cnt_q   <= '0;
      burst_cnt_q   <= '0;
      blocks_left_q <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      mcu_idx_q     <= '0;
      en_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iSTART) begin
            mode_q        <= decode_mode(iMODE);
            blank_mode_q  <= len_mode_e'(iBLANK_MOD);
            burst_mode_q  <= len_mode_e'(iBURST_MOD);
            blank_val_q   <= iBLANK_VAL;
            burst_val_q   <= iBURST_VAL;
            blocks_left_q <= iBLOCKS;
            addr_q        <= '0;
            cnt_q         <= '0;
            mcu_idx_q     <= '0;
            busy_q        <= 1'b1;
            if (iBLOCKS == 32'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StBlank;
              // The LFSR is being reloaded this edge, so draw from the seed itself.
              blank_cnt_q <= blank_draw(len_mode_e'(iBLANK_MOD), SeedFixed, iBLANK_VAL);
            end
          end
        end
        StBlank: begin
          // Lengths 0 and 1 both give a single blank cycle.
          if (blank_cnt_q <= 16'd1) begin
            state_q     <= StBurst;
            en_q        <= 1'b1;
            burst_cnt_q <= burst_draw(burst_mode_q, lfsr, burst_val_q);
          end else begin
            blank_cnt_q <= blank_cnt_q - 16'd1;
          end
        end
        StBurst: begin
          if (xfer) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CntMax) begin
              blocks_left_q <= blocks_left_q - 32'd1;
              burst_cnt_q   <= burst_cnt_q - 9'd1;
              mcu_idx_q     <= (mcu_idx_q == mcu_last) ? 3'd0 : mcu_idx_q + 3'd1;
              // Run end wins over burst end.
              if (blocks_left_q == 32'd1) begin
                state_q <= StDone;
                en_q    <= 1'b0;
                done_q  <= 1'b1;
              end else if (burst_cnt_q == 9'd1) begin
                state_q     <= StBlank;
                en_q        <= 1'b0;
                blank_cnt_q <= blank_draw(blank_mode_q, lfsr, blank_val_q);
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oMEM_ADDR = addr_q;
  assign oPO       = iMEM_DAT;
  assign oPO_EN    = en_q;
  assign oPO_DC    = en_q & (cnt_q == '0);
  assign oPO_LAST  = en_q & (cnt_q == CntMax);
  assign oPO_ID    = comp_id(mode_q, mcu_idx_q);
  assign oBUSY     = busy_q;
  assign oDONE     = done_q;

endmodule
